packet_slot_allocator: RTL and testbench

Sequential free-list controller for the packet controller's NUM_ENTRIES-deep packet buffer. It owns the slot-occupancy bitmap and picks the lowest free slot, with the same priority as next_free_index_comb (which may be instantiated internally). It shares that slot among NUM_REQ requesters by round-robin arbitration and returns slots on free requests. It sits between the packet receive/transmit paths and the packet buffer RAM.

---
 rtl/packet_slot_allocator.sv | 200 ++++++++++++++++++++
 tb/tb_packet_slot_allocator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/packet_slot_allocator.sv
// ---------------------------------------------------------------------------
// packet_slot_allocator
//
// Free-list controller for the packet buffer. It keeps a slot-occupancy
// bitmap, hands out the lowest-numbered free slot to one requester per cycle
// (round-robin between requesters), and takes slots back on free requests.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   alloc_req       per-requester level request, held until granted
//   alloc_grant     one-hot registered grant pulse (one cycle)
//   alloc_index     slot handed out with alloc_grant (0 when no grant)
//   free_valid      return the slot named by free_index this cycle
//   free_index      slot being returned
//   flush           synchronous release of every slot (beats alloc/free)
//   free_count      registered number of free slots
//   full            registered, free_count == 0
//   empty           registered, free_count == NUM_ENTRIES
//   double_free_err sticky flag: a free named an already-free slot
//
// Build option:
//   PACKET_SLOT_ALLOC_DOUBLE_FREE_CHECK_EN - when defined, builds the
//   double-free detector; otherwise double_free_err is tied to 0.
// ---------------------------------------------------------------------------
module packet_slot_allocator #(
  parameter  int NUM_ENTRIES = 8,
  parameter  int NUM_REQ     = 2,
  localparam int IDX_W       = $clog2(NUM_ENTRIES),
  localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] alloc_req,
  output logic [NUM_REQ-1:0] alloc_grant,
  output logic [IDX_W-1:0]   alloc_index,
  input  logic               free_valid,
  input  logic [IDX_W-1:0]   free_index,
  input  logic               flush,
  output logic [CNT_W-1:0]   free_count,
  output logic               full,
  output logic               empty,
  output logic               double_free_err
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // (base + off) modulo NUM_REQ, with off < NUM_REQ+1
  function automatic logic [RR_W-1:0] wrap_add(input logic [RR_W-1:0] base,
                                               input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return RR_W'(sum);
  endfunction

  // Registered state
  logic [NUM_ENTRIES-1:0] used_r;
  logic [RR_W-1:0]        rr_ptr_r;
  logic [NUM_REQ-1:0]     grant_r;
  logic [IDX_W-1:0]       index_r;
  logic [CNT_W-1:0]       count_r;
  logic                   full_r;
  logic                   empty_r;

  // Combinational decisions
  logic [IDX_W-1:0]       cand_idx_s;
  logic                   any_free_s;
  logic [RR_W-1:0]        scan_idx_s;
  logic [RR_W-1:0]        win_idx_s;
  logic                   win_found_s;
  logic                   do_alloc_s;
  logic                   free_hit_s;
  logic [NUM_REQ-1:0]     grant_nxt_s;
  logic [NUM_ENTRIES-1:0] used_nxt_s;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic [RR_W-1:0]        rr_nxt_s;

  // Lowest-numbered free slot of the registered bitmap (scan high to low so
  // the last hit written is the lowest index)
  always_comb begin
    cand_idx_s = {IDX_W{1'b0}};
    any_free_s = ~(&used_r);
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!used_r[i]) begin
        cand_idx_s = IDX_W'(i);
      end else begin
        cand_idx_s = cand_idx_s;
      end
    end
  end

  // Round-robin: first asserted requester at or after rr_ptr_r, wrapping
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {RR_W{1'b0}};
    scan_idx_s  = {RR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s = wrap_add(rr_ptr_r, k);
      if (!win_found_s && alloc_req[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant / free qualification, one-hot grant vector and next-state values
  always_comb begin
    do_alloc_s = win_found_s & any_free_s & ~flush;
    // Only a currently used slot counts as a real return; the candidate is
    // free, so an alloc and a free can never name the same slot.
    free_hit_s = free_valid & used_r[free_index] & ~flush;

    grant_nxt_s = {NUM_REQ{1'b0}};
    for (int r = 0; r < NUM_REQ; r++) begin
      grant_nxt_s[r] = do_alloc_s & (win_idx_s == RR_W'(r));
    end

    used_nxt_s = used_r;
    if (flush) begin
      used_nxt_s = {NUM_ENTRIES{1'b0}};
      cnt_nxt_s  = CNT_W'(NUM_ENTRIES);
    end else begin
      if (do_alloc_s) begin
        used_nxt_s[cand_idx_s] = 1'b1;
      end else begin
        used_nxt_s = used_nxt_s;
      end
      if (free_hit_s) begin
        used_nxt_s[free_index] = 1'b0;
      end else begin
        used_nxt_s = used_nxt_s;
      end
      cnt_nxt_s = count_r - {{(CNT_W-1){1'b0}}, do_alloc_s}
                          + {{(CNT_W-1){1'b0}}, free_hit_s};
    end

    // Pointer only moves on an actual grant; it holds while full or flushing
    if (do_alloc_s) begin
      rr_nxt_s = wrap_add(win_idx_s, 1);
    end else begin
      rr_nxt_s = rr_ptr_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used_r   <= {NUM_ENTRIES{1'b0}};
      rr_ptr_r <= {RR_W{1'b0}};
      grant_r  <= {NUM_REQ{1'b0}};
      index_r  <= {IDX_W{1'b0}};
      count_r  <= CNT_W'(NUM_ENTRIES);
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      used_r   <= used_nxt_s;
      rr_ptr_r <= rr_nxt_s;
      grant_r  <= grant_nxt_s;
      index_r  <= do_alloc_s ? cand_idx_s : {IDX_W{1'b0}};
      count_r  <= cnt_nxt_s;
      full_r   <= (cnt_nxt_s == {CNT_W{1'b0}});
      empty_r  <= (cnt_nxt_s == CNT_W'(NUM_ENTRIES));
    end
  end

  assign alloc_grant = grant_r;
  assign alloc_index = index_r;
  assign free_count  = count_r;
  assign full        = full_r;
  assign empty       = empty_r;

`ifdef PACKET_SLOT_ALLOC_DOUBLE_FREE_CHECK_EN
  logic dbl_free_r;

  // Sticky double-free flag, cleared only by reset or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbl_free_r <= 1'b0;
    end else if (flush) begin
      dbl_free_r <= 1'b0;
    end else if (free_valid && !used_r[free_index]) begin
      dbl_free_r <= 1'b1;
    end else begin
      dbl_free_r <= dbl_free_r;
    end
  end

  assign double_free_err = dbl_free_r;
`else
  assign double_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_packet_slot_allocator.sv
// ---------------------------------------------------------------------------
// Testbench for packet_slot_allocator (NUM_ENTRIES=8, NUM_REQ=2).
// A table of per-cycle vectors {inputs, expected outputs after the edge}
// drives the main sequence; hand-written sequences cover reset values and
// an asynchronous reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_packet_slot_allocator;

`ifdef PACKET_SLOT_ALLOC_DOUBLE_FREE_CHECK_EN
  localparam logic DFE = 1'b1;
`else
  localparam logic DFE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] alloc_req;
  logic [1:0] alloc_grant;
  logic [2:0] alloc_index;
  logic       free_valid;
  logic [2:0] free_index;
  logic       flush;
  logic [3:0] free_count;
  logic       full;
  logic       empty;
  logic       double_free_err;

  packet_slot_allocator #(.NUM_ENTRIES(8), .NUM_REQ(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_req       (alloc_req),
    .alloc_grant     (alloc_grant),
    .alloc_index     (alloc_index),
    .free_valid      (free_valid),
    .free_index      (free_index),
    .flush           (flush),
    .free_count      (free_count),
    .full            (full),
    .empty           (empty),
    .double_free_err (double_free_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic       fv;
    logic [2:0] fi;
    logic       fl;
    logic [1:0] eg;
    logic [2:0] ei;
    logic [3:0] ec;
    logic       ed;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void v(input logic [1:0] req, input logic fv,
                            input logic [2:0] fi, input logic fl,
                            input logic [1:0] eg, input logic [2:0] ei,
                            input logic [3:0] ec, input logic ed);
    vec_t t;
    t.req = req; t.fv = fv; t.fi = fi; t.fl = fl;
    t.eg = eg; t.ei = ei; t.ec = ec; t.ed = ed;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] eg,
                            input logic [2:0] ei, input logic [3:0] ec,
                            input logic ed);
    check({tag, " grant"}, int'(alloc_grant), int'(eg));
    if (eg != 2'b00) begin
      check({tag, " index"}, int'(alloc_index), int'(ei));
    end
    check({tag, " count"}, int'(free_count), int'(ec));
    check({tag, " full"},  int'(full),  int'(ec == 4'd0));
    check({tag, " empty"}, int'(empty), int'(ec == 4'd8));
    check({tag, " dferr"}, int'(double_free_err), int'(ed));
  endtask

  task automatic drive(input logic [1:0] req, input logic fv,
                       input logic [2:0] fi, input logic fl);
    @(negedge clk);
    alloc_req  = req;
    free_valid = fv;
    free_index = fi;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    alloc_req  = 2'b00;
    free_valid = 1'b0;
    free_index = 3'd0;
    flush      = 1'b0;
    rst_n      = 1'b0;

    // Reset values (index is 0 in reset)
    #12;
    check("reset grant", int'(alloc_grant), 0);
    check("reset index", int'(alloc_index), 0);
    check_outs("reset", 2'b00, 3'd0, 4'd8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    v(2'b00, 1'b0, 3'd0, 1'b0, 2'b00, 3'd0, 4'd8, 1'b0);
    // Both requesters held: alternate 0,1 from pointer 0, slots 0..7
    for (int i = 0; i < 8; i++) begin
      v(2'b11, 1'b0, 3'd0, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10,
        3'(i), 4'(7 - i), 1'b0);
    end
    // Full: free slot 5 -> no grant this edge (no bypass), count 1
    v(2'b11, 1'b1, 3'd5, 1'b0, 2'b00, 3'd0, 4'd1, 1'b0);
    // Two edges after the free, slot 5 goes to requester 0 (pointer 0)
    v(2'b11, 1'b0, 3'd0, 1'b0, 2'b01, 3'd5, 4'd0, 1'b0);
    // Full again: nothing granted, requests stay pending
    v(2'b11, 1'b0, 3'd0, 1'b0, 2'b00, 3'd0, 4'd0, 1'b0);
    v(2'b00, 1'b0, 3'd0, 1'b0, 2'b00, 3'd0, 4'd0, 1'b0);
    // Flush releases everything
    v(2'b00, 1'b0, 3'd0, 1'b1, 2'b00, 3'd0, 4'd8, 1'b0);
    // req0 alone for 3 cycles (pointer at 1 wraps to 0): slots 0,1,2
    v(2'b01, 1'b0, 3'd0, 1'b0, 2'b01, 3'd0, 4'd7, 1'b0);
    v(2'b01, 1'b0, 3'd0, 1'b0, 2'b01, 3'd1, 4'd6, 1'b0);
    v(2'b01, 1'b0, 3'd0, 1'b0, 2'b01, 3'd2, 4'd5, 1'b0);
    // Slot 3, then alloc (slot 4) plus free of slot 1: count stays 4
    v(2'b01, 1'b0, 3'd0, 1'b0, 2'b01, 3'd3, 4'd4, 1'b0);
    v(2'b01, 1'b1, 3'd1, 1'b0, 2'b01, 3'd4, 4'd4, 1'b0);
    v(2'b01, 1'b0, 3'd0, 1'b0, 2'b01, 3'd1, 4'd3, 1'b0);
    v(2'b00, 1'b0, 3'd0, 1'b0, 2'b00, 3'd0, 4'd3, 1'b0);
    // Flush, allocate 6, then flush with req and free in the same cycle
    v(2'b00, 1'b0, 3'd0, 1'b1, 2'b00, 3'd0, 4'd8, 1'b0);
    for (int i = 0; i < 6; i++) begin
      v(2'b01, 1'b0, 3'd0, 1'b0, 2'b01, 3'(i), 4'(7 - i), 1'b0);
    end
    v(2'b01, 1'b1, 3'd2, 1'b1, 2'b00, 3'd0, 4'd8, 1'b0);
    v(2'b00, 1'b0, 3'd0, 1'b0, 2'b00, 3'd0, 4'd8, 1'b0);
    v(2'b01, 1'b0, 3'd0, 1'b0, 2'b01, 3'd0, 4'd7, 1'b0);
    // Double free of slot 2: count unchanged, flag only with the checker
    v(2'b00, 1'b1, 3'd2, 1'b0, 2'b00, 3'd0, 4'd7, DFE);
    // Legal free of slot 0, flag stays sticky
    v(2'b00, 1'b1, 3'd0, 1'b0, 2'b00, 3'd0, 4'd8, DFE);
    // Flush clears the flag
    v(2'b00, 1'b0, 3'd0, 1'b1, 2'b00, 3'd0, 4'd8, 1'b0);
    // Requester 1 alone: pointer 1 -> grant 1; pointer 0 -> wraps to 1
    v(2'b10, 1'b0, 3'd0, 1'b0, 2'b10, 3'd0, 4'd7, 1'b0);
    v(2'b10, 1'b0, 3'd0, 1'b0, 2'b10, 3'd1, 4'd6, 1'b0);
    // Both requesting, pointer 0 -> requester 0 gets slot 2
    v(2'b11, 1'b0, 3'd0, 1'b0, 2'b01, 3'd2, 4'd5, 1'b0);

    foreach (vecs[n]) begin
      drive(vecs[n].req, vecs[n].fv, vecs[n].fi, vecs[n].fl);
      check_outs($sformatf("vec%0d", n), vecs[n].eg, vecs[n].ei,
                 vecs[n].ec, vecs[n].ed);
    end

    // Asynchronous reset mid-cycle, right after a grant was issued
    drive(2'b01, 1'b0, 3'd0, 1'b0);
    check_outs("pre-rst", 2'b01, 3'd3, 4'd4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async-rst index", int'(alloc_index), 0);
    check_outs("async-rst", 2'b00, 3'd0, 4'd8, 1'b0);
    @(negedge clk);
    alloc_req = 2'b00;
    rst_n     = 1'b1;
    // Bitmap and pointer are back at reset: both requesting -> req0, slot 0
    drive(2'b11, 1'b0, 3'd0, 1'b0);
    check_outs("post-rst", 2'b01, 3'd0, 4'd7, 1'b0);
    drive(2'b00, 1'b0, 3'd0, 1'b0);
    check_outs("post-rst idle", 2'b00, 3'd0, 4'd7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
